// File: rtl/gsim_ring_shreg.sv
// Circular operand buffer for the Gauss-Seidel datapath: shift, rotate, rotate-insert, clear, fixed taps.
// Optional GSIM_SHREG_TAP_REG_EN registers tap_data for one extra cycle of latency.
module gsim_ring_shreg #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 16,
   parameter  int NUM_TAPS = 7,
   localparam int AW       = $clog2(DEPTH),
   parameter  logic [NUM_TAPS*AW-1:0] TAP_OFFS = 28'h1F2E3D0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [AW-1:0]             rot_amt,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic [NUM_TAPS*WIDTH-1:0] tap_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [AW:0]               count,
   output logic                      full
);

   typedef enum logic [1:0] {OP_SHIFT, OP_ROT, OP_ROT_INS, OP_CLEAR} op_e;

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];
   logic [WIDTH-1:0] rot     [DEPTH];
   logic [NUM_TAPS*WIDTH-1:0] tap_c;
   op_e  op;
   logic accept, ins, evict;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = !(op == OP_SHIFT && out_valid && !out_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign ins       = accept && in_valid && (op == OP_SHIFT || op == OP_ROT_INS);
   assign evict     = accept && in_valid && op == OP_SHIFT;
   assign full      = (count == (AW+1)'(DEPTH));

   // Physical storage is kept in logical order; rotation is a per-entry mux.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_rot
         assign rot[gi] = mem[AW'(gi) + rot_amt];
      end
   endgenerate

   always_comb begin
      mem_nxt = mem;
      case (op)
         OP_SHIFT: if (in_valid) begin
            for (int i = 0; i < DEPTH-1; i++) mem_nxt[i] = mem[i+1];
            mem_nxt[DEPTH-1] = in_data;
         end
         OP_ROT: mem_nxt = rot;
         OP_ROT_INS: begin
            mem_nxt = rot;
            if (in_valid) mem_nxt[DEPTH-1] = in_data;
         end
         default: for (int i = 0; i < DEPTH; i++) mem_nxt[i] = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (accept) begin
         mem <= mem_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (accept && op == OP_CLEAR) begin
         count <= '0;
      end else if (ins && !full) begin
         count <= count + (AW+1)'(1);
      end
   end

   // A new eviction reloads the port in the same cycle the old entry drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (evict) begin
         out_valid <= 1'b1;
         out_data  <= mem[0];
      end else if (accept && op == OP_CLEAR) begin
         out_valid <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   genvar gt;
   generate
      for (gt = 0; gt < NUM_TAPS; gt++) begin : g_tap
         assign tap_c[gt*WIDTH +: WIDTH] = mem[TAP_OFFS[gt*AW +: AW]];
      end
   endgenerate

`ifdef GSIM_SHREG_TAP_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tap_data <= '0;
      else        tap_data <= tap_c;
   end
`else
   assign tap_data = tap_c;
`endif

endmodule
